// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// opcode field location and FSM state encoding.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int INST_W_DEF = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam logic [OPC_MSB-OPC_LSB:0] OPC_NOP = 4'b0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_nop(input logic [OPC_MSB-OPC_LSB:0] opc);
        return (opc == OPC_NOP);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: ROM port, decode handshake, redirect and halt control.
// master = fetch unit side, slave = ROM/decode/control side.
interface fetch_unit_if #(
    parameter int ADDR_W = fetch_unit_pkg::ADDR_W_DEF,
    parameter int INST_W = fetch_unit_pkg::INST_W_DEF
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              halted;

    modport master (
        output rom_addr,
        input  rom_data,
        output inst_out,
        output inst_pc,
        output inst_valid,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output halted
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst_out,
        input  inst_pc,
        input  inst_valid,
        output inst_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  halted
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc, one-entry instruction holding register, RUN/HALT FSM.
// Defining FETCH_NOP_SKIP_EN drops opcode-0000 words instead of delivering them.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | fetching; a word is loaded whenever the holding register frees
// ST_HALT | fetch stopped; held instruction stays until taken or redirected
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

`ifdef FETCH_NOP_SKIP_EN
    localparam bit NOP_SKIP = 1'b1;
`else
    localparam bit NOP_SKIP = 1'b0;
`endif

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [INST_W-1:0] inst_out_q, inst_out_nxt;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_nxt;
    logic              valid_q, valid_nxt;
    logic              fetch;
    logic              nop_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            pc         <= '0;
            inst_out_q <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_out_q <= inst_out_nxt;
            inst_pc_q  <= inst_pc_nxt;
            valid_q    <= valid_nxt;
        end
    end

    assign fetch = (state == ST_RUN) && !bus.halt_req && !bus.redirect_valid &&
                   (!valid_q || bus.inst_ready);

    // Constant-folds to 0 when skipping is not built in.
    assign nop_hit = NOP_SKIP && is_nop(bus.rom_data[OPC_MSB:OPC_LSB]);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_out_nxt = inst_out_q;
        inst_pc_nxt  = inst_pc_q;
        valid_nxt    = valid_q;

        if (bus.redirect_valid) begin
            pc_nxt    = bus.redirect_pc;
            valid_nxt = 1'b0;
        end else if (fetch) begin
            // pc wraps naturally at 2^ADDR_W
            pc_nxt = pc + ADDR_W'(1);
            if (nop_hit) begin
                valid_nxt = 1'b0;
            end else begin
                inst_out_nxt = bus.rom_data;
                inst_pc_nxt  = pc;
                valid_nxt    = 1'b1;
            end
        end else if (valid_q && bus.inst_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            ST_RUN:  if (bus.halt_req)  state_nxt = ST_HALT;
            ST_HALT: if (!bus.halt_req) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign bus.rom_addr   = pc;
    assign bus.inst_out   = inst_out_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.halted     = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall, wrap, redirect, halt and mid-run reset.
module tb_fetch_unit;

    localparam int AW = 4;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [IW-1:0] rom [16];

    fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    fetch_unit #(.ADDR_W(AW), .INST_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inst(input string tag, input int pc_exp, input int addr_exp);
        check({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
        check({tag, "_pc"}, {28'd0, bus.inst_pc}, pc_exp);
        check({tag, "_out"}, {16'd0, bus.inst_out}, {16'd0, rom[pc_exp]});
        check({tag, "_addr"}, {28'd0, bus.rom_addr}, addr_exp);
    endtask

    initial begin
        rom[0] = 16'h1202;
        rom[1] = 16'h0200;
        rom[2] = 16'hF200;
        for (int i = 3; i < 16; i++) rom[i] = 16'hA000 | 16'(i);

        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt_req       = 1'b0;

        tick();
        tick();
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc", {28'd0, bus.inst_pc}, 32'd0);
        check("rst_out", {16'd0, bus.inst_out}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_addr", {28'd0, bus.rom_addr}, 32'd0);
        rst = 1'b0;

        tick();
        check_inst("first", 0, 1);
`ifdef FETCH_NOP_SKIP_EN
        tick();
        check("nop_skipped", {31'd0, bus.inst_valid}, 32'd0);
        check("nop_addr", {28'd0, bus.rom_addr}, 32'd2);
        tick();
        check_inst("after_nop", 2, 3);
`else
        tick();
        check_inst("second", 1, 2);
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_inst("stall", 1, 2);
        end
        bus.inst_ready = 1'b1;
        tick();
        check_inst("after_stall", 2, 3);
`endif

        for (int k = 1; k <= 14; k++) begin
            tick();
            check_inst("freerun", (2 + k) % 16, (3 + k) % 16);
        end

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 4'd9;
        tick();
        bus.redirect_valid = 1'b0;
        check("redir_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("redir_addr", {28'd0, bus.rom_addr}, 32'd9);
        tick();
        check_inst("redir_fetch", 9, 10);

        bus.halt_req = 1'b1;
        tick();
        check("halt_halted", {31'd0, bus.halted}, 32'd1);
        check("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("halt_addr", {28'd0, bus.rom_addr}, 32'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", {31'd0, bus.halted}, 32'd1);
            check("halt_pc_frozen", {28'd0, bus.rom_addr}, 32'd10);
        end
        bus.halt_req = 1'b0;
        tick();
        check("resume_halted", {31'd0, bus.halted}, 32'd0);
        check("resume_addr", {28'd0, bus.rom_addr}, 32'd10);
        tick();
        check_inst("resume_fetch", 10, 11);

        bus.inst_ready = 1'b0;
        bus.halt_req   = 1'b1;
        tick();
        check("halt_keep_halted", {31'd0, bus.halted}, 32'd1);
        check_inst("halt_keep", 10, 11);
        bus.inst_ready = 1'b1;
        bus.halt_req   = 1'b0;
        tick();
        check("drain_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        check_inst("post_drain", 11, 12);

        #3 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("arst_pc", {28'd0, bus.inst_pc}, 32'd0);
        check("arst_out", {16'd0, bus.inst_out}, 32'd0);
        check("arst_addr", {28'd0, bus.rom_addr}, 32'd0);
        tick();
        rst = 1'b0;
        check("arst_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        check_inst("arst_first", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
